rgb_pwm_driver: RTL and testbench

Downstream stage of the colour converter. Accepts a 24-bit RGB code (R=[23:16], G=[15:8], B=[7:0]) and drives three PWM outputs for a tri-colour LED, one duty cycle per channel. New colours are buffered in a shadow register and applied only at a PWM period boundary, so outputs never glitch mid-period.

---
 rtl/rgb_pwm_driver.sv | 170 +++++++++++++++++
 tb/tb_rgb_pwm_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// ---------------------------------------------------------------------------
// rgb_pwm_driver
//
// Purpose:
//   Turns a 24-bit RGB code into three PWM outputs for a tri-colour LED.
//   A new colour is accepted into a shadow register and copied into the
//   active duty registers only when a PWM period ends. This keeps every
//   period's waveform consistent and free of glitches.
//
// Parameters:
//   PRESCALE  clock cycles per PWM tick (1..65535); period = 256*PRESCALE
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable        run enable; low freezes counters and forces LEDs off
//   rgb[23:0]     colour code, R=[23:16] G=[15:8] B=[7:0]
//   rgb_valid     rgb is valid this cycle
//   rgb_ready     shadow register empty, a colour can be accepted
//   led_r/g/b     active-high PWM outputs
//   period_start  one-cycle pulse on the first clock of each PWM period
//
// Build options:
//   GAMMA_EN      when defined, applied duty = (c*c)>>8 per channel
// ---------------------------------------------------------------------------
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] rgb,
    input  logic        rgb_valid,
    output logic        rgb_ready,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        period_start
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CH_W  = 8;
    localparam int unsigned RGB_W = 3 * CH_W;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // Per-channel duty transform applied on the shadow-to-active copy
    function automatic logic [CH_W-1:0] duty_map(input logic [CH_W-1:0] c);
`ifdef GAMMA_EN
        logic [2*CH_W-1:0] prod;
        prod = (2*CH_W)'(c) * (2*CH_W)'(c);
        return prod[2*CH_W-1:CH_W];
`else
        return c;
`endif
    endfunction

    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] pwm_cnt;
    logic             tick_c;
    logic             boundary_c;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [RGB_W-1:0] shadow_q;
    logic [RGB_W-1:0] shadow_d;
    logic             load_c;

    logic [CH_W-1:0]  duty_r;
    logic [CH_W-1:0]  duty_g;
    logic [CH_W-1:0]  duty_b;

    // A tick only happens while running; the boundary is the last tick of a period
    assign tick_c     = enable && (pre_cnt == PRE_MAX);
    assign boundary_c = tick_c && (pwm_cnt == CNT_MAX);

    // Prescaler: 0..PRESCALE-1, holds while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (enable) begin
            if (tick_c) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    // PWM position counter, natural 8-bit wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick_c) begin
            pwm_cnt <= pwm_cnt + CNT_W'(1);
        end
    end

    // Handshake FSM state, shadow register and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            rgb_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            rgb_ready <= (state_d == ST_IDLE);
        end
    end

    // Next-state: capture in IDLE, transfer on boundary in PENDING
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        load_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rgb_valid) begin
                    shadow_d = rgb;
                    state_d  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // rgb_valid is deliberately ignored here; ready was low
                if (boundary_c) begin
                    load_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Active duty registers, updated only at a period boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r <= '0;
            duty_g <= '0;
            duty_b <= '0;
        end else if (load_c) begin
            duty_r <= duty_map(shadow_q[23:16]);
            duty_g <= duty_map(shadow_q[15:8]);
            duty_b <= duty_map(shadow_q[7:0]);
        end
    end

    // Registered compare; duty 255 gives 255/256 since pwm_cnt never exceeds 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r        <= 1'b0;
            led_g        <= 1'b0;
            led_b        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            led_r        <= enable && (pwm_cnt < duty_r);
            led_g        <= enable && (pwm_cnt < duty_g);
            led_b        <= enable && (pwm_cnt < duty_b);
            period_start <= boundary_c;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_driver
//
// Directed bench for rgb_pwm_driver. u_dut runs with PRESCALE=1 for the
// handshake, freeze and reset scenarios. u_dut2 runs with PRESCALE=2 for
// the duty-mapping scenario, and its expectations follow GAMMA_EN.
// Inputs are driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rgb_pwm_driver;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic        rgb_ready;
    logic        led_r;
    logic        led_g;
    logic        led_b;
    logic        period_start;

    logic [23:0] rgb2;
    logic        rgb_valid2;
    logic        rgb_ready2;
    logic        led_r2;
    logic        led_g2;
    logic        led_b2;
    logic        period_start2;

    int vecs;
    int errs;
    int hr, hg, hb, hp;
    int cnt_a, cnt_b;
    bit found;

    rgb_pwm_driver #(.PRESCALE(1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rgb          (rgb),
        .rgb_valid    (rgb_valid),
        .rgb_ready    (rgb_ready),
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b),
        .period_start (period_start)
    );

    rgb_pwm_driver #(.PRESCALE(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rgb          (rgb2),
        .rgb_valid    (rgb_valid2),
        .rgb_ready    (rgb_ready2),
        .led_r        (led_r2),
        .led_g        (led_g2),
        .led_b        (led_b2),
        .period_start (period_start2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count high samples per output over n falling edges
    task automatic measure(input int n, input bit sel2,
                           output int r, output int g, output int b, output int p);
        r = 0; g = 0; b = 0; p = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel2) begin
                r += led_r2 ? 1 : 0;
                g += led_g2 ? 1 : 0;
                b += led_b2 ? 1 : 0;
                p += period_start2 ? 1 : 0;
            end else begin
                r += led_r ? 1 : 0;
                g += led_g ? 1 : 0;
                b += led_b ? 1 : 0;
                p += period_start ? 1 : 0;
            end
        end
    endtask

    // Advance to the next period_start sample, bounded
    task automatic wait_ps(input bit sel2, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = sel2 ? period_start2 : period_start;
        end
    endtask

    initial begin
        vecs       = 0;
        errs       = 0;
        rst_n      = 1'b0;
        enable     = 1'b1;
        rgb        = '0;
        rgb_valid  = 1'b0;
        rgb2       = '0;
        rgb_valid2 = 1'b0;

        // 1: reset state, then dark for two periods
        repeat (3) @(negedge clk);
        check("rst_led_r", led_r, 0);
        check("rst_led_g", led_g, 0);
        check("rst_led_b", led_b, 0);
        check("rst_ps", period_start, 0);
        check("rst_ready", rgb_ready, 1);
        rst_n = 1'b1;
        measure(512, 1'b0, hr, hg, hb, hp);
        check("t1_r_high", hr, 0);
        check("t1_g_high", hg, 0);
        check("t1_b_high", hb, 0);
        check("t1_ps_count", hp, 2);
        check("t1_ready", rgb_ready, 1);

        // 2: load FF8000, ready low until the boundary
        rgb = 24'hFF8000; rgb_valid = 1'b1;
        @(negedge clk);
        rgb_valid = 1'b0;
        check("t2_ready_low", rgb_ready, 0);
        wait_ps(1'b0, 600, found);
        check("t2_boundary_seen", found, 1);
        check("t2_ready_back", rgb_ready, 1);
        measure(256, 1'b0, hr, hg, hb, hp);
        check("t2_p1_r", hr, 255);
        check("t2_p1_g", hg, 128);
        check("t2_p1_b", hb, 0);
        check("t2_p1_ps", hp, 1);
        measure(256, 1'b0, hr, hg, hb, hp);
        check("t2_p2_r", hr, 255);
        check("t2_p2_g", hg, 128);
        check("t2_p2_ps", hp, 1);

        // 3: second colour offered while pending is ignored
        rgb = 24'h0000FF; rgb_valid = 1'b1;
        @(negedge clk);
        rgb = 24'h00FF00;
        check("t3_ready_pending", rgb_ready, 0);
        @(negedge clk);
        rgb_valid = 1'b0;
        wait_ps(1'b0, 600, found);
        check("t3_boundary_seen", found, 1);
        measure(256, 1'b0, hr, hg, hb, hp);
        check("t3_r", hr, 0);
        check("t3_g", hg, 0);
        check("t3_b", hb, 255);

        // 3a: valid on the boundary cycle in IDLE is captured, applied one period later
        repeat (255) @(negedge clk);
        rgb = 24'hFF0000; rgb_valid = 1'b1;
        @(negedge clk);
        rgb_valid = 1'b0;
        check("t3a_ps_now", period_start, 1);
        check("t3a_ready_pending", rgb_ready, 0);
        measure(256, 1'b0, hr, hg, hb, hp);
        check("t3a_old_r", hr, 0);
        check("t3a_old_b", hb, 255);
        check("t3a_ready_after", rgb_ready, 1);
        measure(256, 1'b0, hr, hg, hb, hp);
        check("t3a_new_r", hr, 255);
        check("t3a_new_b", hb, 0);

        // 3b: valid on the boundary cycle in PENDING is dropped
        rgb = 24'h00FF00; rgb_valid = 1'b1;
        @(negedge clk);
        rgb_valid = 1'b0;
        repeat (254) @(negedge clk);
        rgb = 24'h0000FF; rgb_valid = 1'b1;
        @(negedge clk);
        rgb_valid = 1'b0;
        check("t3b_ps_now", period_start, 1);
        check("t3b_ready", rgb_ready, 1);
        measure(256, 1'b0, hr, hg, hb, hp);
        check("t3b_g", hg, 255);
        check("t3b_r", hr, 0);
        measure(256, 1'b0, hr, hg, hb, hp);
        check("t3b_dropped_b", hb, 0);
        check("t3b_still_g", hg, 255);

        // 4: freeze at pwm_cnt=100 for 50 clocks (active duty G=255)
        measure(100, 1'b0, hr, hg, hb, hp);
        check("t4_pre_g", hg, 100);
        enable = 1'b0;
        measure(50, 1'b0, hr, hg, hb, hp);
        check("t4_frozen_leds", hr + hg + hb, 0);
        check("t4_frozen_ps", hp, 0);
        enable = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            cnt_a++;
            cnt_b += led_g ? 1 : 0;
            found = period_start;
        end
        check("t4_boundary_seen", found, 1);
        check("t4_resume_len", cnt_a, 156);
        check("t4_resume_g", cnt_b, 155);

        // 5: reset mid-period while pending
        rgb = 24'h0000FF; rgb_valid = 1'b1;
        @(negedge clk);
        rgb_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_g_on_before", led_g, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_g_async_off", led_g, 0);
        check("t5_ready_in_rst", rgb_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        measure(512, 1'b0, hr, hg, hb, hp);
        check("t5_r", hr, 0);
        check("t5_g", hg, 0);
        check("t5_b_never", hb, 0);
        check("t5_ps_count", hp, 2);
        check("t5_ready", rgb_ready, 1);

        // 6: PRESCALE=2 instance, colour 80FF01
        rgb2 = 24'h80FF01; rgb_valid2 = 1'b1;
        @(negedge clk);
        rgb_valid2 = 1'b0;
        check("t6_ready2_low", rgb_ready2, 0);
        wait_ps(1'b1, 1200, found);
        check("t6_boundary_seen", found, 1);
        measure(512, 1'b1, hr, hg, hb, hp);
`ifdef GAMMA_EN
        check("t6_r", hr, 128);
        check("t6_g", hg, 508);
        check("t6_b", hb, 0);
`else
        check("t6_r", hr, 256);
        check("t6_g", hg, 510);
        check("t6_b", hb, 2);
`endif
        check("t6_ps", hp, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
